// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer.
package run_seq_pkg;

  // Sequencer phases.
  typedef enum logic [2:0] {
    StIdle,
    StCoreRst,
    StRun,
    StVga,
    StDone
  } run_state_e;

  // RUN-cycle counter type.
  typedef logic [31:0] count_t;

  // Saturation ceiling for the RUN-cycle counter.
  localparam count_t CountSat = 32'hFFFF_FFFF;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic count_t sat_inc(input count_t value);
    return (value == CountSat) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/core_done_latch.sv
// Sticky per-core completion flag: set by a qualified done, cleared on a new run or reset.
module core_done_latch (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_set,
  output logic o_done
);

  logic r_done;

  // Clear has priority so a fresh run always starts with the flag low.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_done <= 1'b0;
    end else if (i_set) begin
      r_done <= 1'b1;
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/run_sequencer.sv
// Sequences CPU cores through reset and run, then launches one VGA frame scan-out.
// Optional watchdog: define RUN_SEQ_WATCHDOG_EN to abort a RUN phase that exceeds
// TIMEOUT_CYCLES; without it o_timeout is tied low and no comparator exists.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned NUM_CORES      = 2,
  parameter int unsigned WAIT_ALL       = 1,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NUM_CORES-1:0] i_core_done,
  output logic [NUM_CORES-1:0] o_core_rst,
  output logic [NUM_CORES-1:0] o_core_en,
  output logic                 o_vga_start,
  input  logic                 i_vga_done,
  output logic                 o_busy,
  output logic                 o_finished,
  output logic                 o_timeout,
  output logic [31:0]          o_cycle_count
);

  localparam logic [7:0] RstLast = 8'(RST_CYCLES - 1);

  run_state_e           r_state;
  run_state_e           w_state_d;
  logic [7:0]           r_rst_cnt;
  logic [7:0]           w_rst_cnt_d;
  count_t               r_count;
  count_t               w_count_d;
  count_t               w_count_inc;
  logic                 r_vga_start;
  logic                 w_vga_start_d;
  logic                 w_clear;
  logic                 w_run_exit;
  logic [NUM_CORES-1:0] w_latch_set;
  logic [NUM_CORES-1:0] w_latched;
  logic [NUM_CORES-1:0] w_done_now;

  // Per-core sticky done flags; only a done seen during RUN counts.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_latch
    assign w_latch_set[g] = (r_state == StRun) && i_core_done[g];

    core_done_latch u_latch (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_clear (w_clear),
      .i_set   (w_latch_set[g]),
      .o_done  (w_latched[g])
    );
  end

  // Include this cycle's done so exit and latching happen on the same edge.
  assign w_done_now  = w_latched | i_core_done;
  assign w_run_exit  = (WAIT_ALL != 0) ? (&w_done_now) : (|w_done_now);
  assign w_count_inc = sat_inc(r_count);

`ifdef RUN_SEQ_WATCHDOG_EN
  logic r_timeout;
  logic w_timeout_d;
`endif

  // State and datapath registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_rst_cnt   <= '0;
      r_count     <= '0;
      r_vga_start <= 1'b0;
`ifdef RUN_SEQ_WATCHDOG_EN
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_rst_cnt   <= w_rst_cnt_d;
      r_count     <= w_count_d;
      r_vga_start <= w_vga_start_d;
`ifdef RUN_SEQ_WATCHDOG_EN
      r_timeout   <= w_timeout_d;
`endif
    end
  end

  // Next-state and per-state outputs.
  always_comb begin
    w_state_d     = r_state;
    w_rst_cnt_d   = r_rst_cnt;
    w_count_d     = r_count;
    w_vga_start_d = 1'b0;
    w_clear       = 1'b0;
    o_core_rst    = '0;
    o_core_en     = '0;
    o_busy        = 1'b1;
    o_finished    = 1'b0;
`ifdef RUN_SEQ_WATCHDOG_EN
    w_timeout_d   = r_timeout;
`endif

    unique case (r_state)
      StIdle, StDone: begin
        o_busy     = 1'b0;
        o_finished = (r_state == StDone);
        o_core_rst = (r_state == StIdle) ? '1 : '0;
        if (i_start) begin
          w_state_d   = StCoreRst;
          w_rst_cnt_d = '0;
          w_count_d   = '0;
          w_clear     = 1'b1;
`ifdef RUN_SEQ_WATCHDOG_EN
          w_timeout_d = 1'b0;
`endif
        end
      end

      StCoreRst: begin
        o_core_rst = '1;
        if (r_rst_cnt == RstLast) begin
          w_state_d = StRun;
        end else begin
          w_rst_cnt_d = r_rst_cnt + 8'd1;
        end
      end

      StRun: begin
        o_core_en = ~w_latched;
        w_count_d = w_count_inc;
`ifdef RUN_SEQ_WATCHDOG_EN
        // Watchdog abort skips scan-out entirely.
        if (w_count_inc >= count_t'(TIMEOUT_CYCLES)) begin
          w_timeout_d = 1'b1;
          w_state_d   = StDone;
        end else if (w_run_exit) begin
          w_state_d     = StVga;
          w_vga_start_d = 1'b1;
        end
`else
        if (w_run_exit) begin
          w_state_d     = StVga;
          w_vga_start_d = 1'b1;
        end
`endif
      end

      StVga: begin
        // A done level on the launch cycle belongs to a previous frame.
        if (!r_vga_start && i_vga_done) begin
          w_state_d = StDone;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign o_vga_start   = r_vga_start;
  assign o_cycle_count = r_count;

`ifdef RUN_SEQ_WATCHDOG_EN
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench: instance A uses WAIT_ALL=1, instance B uses WAIT_ALL=0.
// Both use RST_CYCLES=4 and TIMEOUT_CYCLES=50.
module tb_run_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, a_vga_done, a_vga_start, a_busy, a_finished, a_timeout;
  logic [1:0]  a_core_done, a_core_rst, a_core_en;
  logic [31:0] a_count;
  logic        b_start, b_vga_done, b_vga_start, b_busy, b_finished, b_timeout;
  logic [1:0]  b_core_done, b_core_rst, b_core_en;
  logic [31:0] b_count;

  int n_checks = 0;
  int n_errors = 0;
  int a_pulses = 0;
  int b_pulses = 0;

  run_sequencer #(
    .NUM_CORES      (2),
    .WAIT_ALL       (1),
    .RST_CYCLES     (4),
    .TIMEOUT_CYCLES (50)
  ) u_dut_a (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (a_start),
    .i_core_done   (a_core_done),
    .o_core_rst    (a_core_rst),
    .o_core_en     (a_core_en),
    .o_vga_start   (a_vga_start),
    .i_vga_done    (a_vga_done),
    .o_busy        (a_busy),
    .o_finished    (a_finished),
    .o_timeout     (a_timeout),
    .o_cycle_count (a_count)
  );

  run_sequencer #(
    .NUM_CORES      (2),
    .WAIT_ALL       (0),
    .RST_CYCLES     (4),
    .TIMEOUT_CYCLES (50)
  ) u_dut_b (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (b_start),
    .i_core_done   (b_core_done),
    .o_core_rst    (b_core_rst),
    .o_core_en     (b_core_en),
    .o_vga_start   (b_vga_start),
    .i_vga_done    (b_vga_done),
    .o_busy        (b_busy),
    .o_finished    (b_finished),
    .o_timeout     (b_timeout),
    .o_cycle_count (b_count)
  );

  // Count scan-out launches per instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_vga_start) a_pulses++;
    if (b_vga_start) b_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_vga_done = 1'b0; a_core_done = 2'b00;
    b_start = 1'b0; b_vga_done = 1'b0; b_core_done = 2'b00;
    tick();
    tick();

    // Reset values
    check_eq("rst_core_rst", 32'(a_core_rst), 32'h3);
    check_eq("rst_core_en", 32'(a_core_en), 32'h0);
    check_eq("rst_vga_start", 32'(a_vga_start), 32'h0);
    check_eq("rst_busy", 32'(a_busy), 32'h0);
    check_eq("rst_finished", 32'(a_finished), 32'h0);
    check_eq("rst_timeout", 32'(a_timeout), 32'h0);
    check_eq("rst_count", a_count, 32'h0);
    rst = 1'b0;
    tick();

    // Done inputs while idle do nothing
    a_core_done = 2'b11; a_vga_done = 1'b1;
    tick();
    a_core_done = 2'b00; a_vga_done = 1'b0;
    check_eq("idle_busy", 32'(a_busy), 32'h0);
    check_eq("idle_finished", 32'(a_finished), 32'h0);

    // A: core reset window then WAIT_ALL run
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("crst_core_rst", 32'(a_core_rst), 32'h3);
      check_eq("crst_core_en", 32'(a_core_en), 32'h0);
      check_eq("crst_busy", 32'(a_busy), 32'h1);
      tick();
    end
    check_eq("run_core_rst", 32'(a_core_rst), 32'h0);
    for (int k = 0; k <= 25; k++) begin
      check_eq("run_count", a_count, 32'(k));
      check_eq("run_en", 32'(a_core_en), (k <= 10) ? 32'h3 : 32'h2);
      a_core_done = {k == 25, k == 10};
      a_start     = (k == 12);
      tick();
    end
    a_core_done = 2'b00;
    a_start     = 1'b0;

    // A: VGA phase
    check_eq("vga_en_off", 32'(a_core_en), 32'h0);
    check_eq("vga_start_pulse", 32'(a_vga_start), 32'h1);
    check_eq("vga_count", a_count, 32'd26);
    check_eq("vga_busy", 32'(a_busy), 32'h1);
    a_vga_done = 1'b1;
    tick();
    a_vga_done = 1'b0;
    check_eq("vga_start_once", 32'(a_vga_start), 32'h0);
    check_eq("vga_early_done_ign", 32'(a_finished), 32'h0);
    tick();
    check_eq("vga_count_hold", a_count, 32'd26);
    a_vga_done = 1'b1;
    tick();
    a_vga_done = 1'b0;
    check_eq("done_finished", 32'(a_finished), 32'h1);
    check_eq("done_busy", 32'(a_busy), 32'h0);
    check_eq("done_count", a_count, 32'd26);
    check_eq("done_timeout", 32'(a_timeout), 32'h0);
    check_eq("a_pulse_total", 32'(a_pulses), 32'd1);
    a_core_done = 2'b11; a_vga_done = 1'b1;
    tick();
    a_core_done = 2'b00; a_vga_done = 1'b0;
    check_eq("done_ignore_inputs", 32'(a_finished), 32'h1);
    check_eq("done_count_hold", a_count, 32'd26);

    // B: WAIT_ALL=0, core 1 done at run cycle 7
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (4) tick();
    for (int k = 0; k <= 7; k++) begin
      check_eq("b_run_en", 32'(b_core_en), 32'h3);
      b_core_done = {k == 7, 1'b0};
      tick();
    end
    b_core_done = 2'b00;
    check_eq("b_vga_en_off", 32'(b_core_en), 32'h0);
    check_eq("b_vga_start", 32'(b_vga_start), 32'h1);
    check_eq("b_count", b_count, 32'd8);
    tick();
    tick();
    check_eq("b_vga_wait", 32'(b_finished), 32'h0);
    tick();
    b_vga_done = 1'b1;
    tick();
    b_vga_done = 1'b0;
    check_eq("b_finished", 32'(b_finished), 32'h1);
    check_eq("b_busy", 32'(b_busy), 32'h0);
    check_eq("b_pulse_total", 32'(b_pulses), 32'd1);

    // B: restart from DONE with no core ever done
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check_eq("wd_clr_finished", 32'(b_finished), 32'h0);
    check_eq("wd_clr_count", b_count, 32'h0);
    check_eq("wd_clr_timeout", 32'(b_timeout), 32'h0);
    repeat (4) tick();
    check_eq("wd_run_en", 32'(b_core_en), 32'h3);
`ifdef RUN_SEQ_WATCHDOG_EN
    repeat (49) tick();
    check_eq("wd_pre_busy", 32'(b_busy), 32'h1);
    check_eq("wd_pre_timeout", 32'(b_timeout), 32'h0);
    tick();
    check_eq("wd_timeout", 32'(b_timeout), 32'h1);
    check_eq("wd_finished", 32'(b_finished), 32'h1);
    check_eq("wd_count", b_count, 32'd50);
    check_eq("wd_en_off", 32'(b_core_en), 32'h0);
    check_eq("wd_no_vga", 32'(b_pulses), 32'd1);
`else
    repeat (200) tick();
    check_eq("nowd_busy", 32'(b_busy), 32'h1);
    check_eq("nowd_count", b_count, 32'd200);
    check_eq("nowd_timeout", 32'(b_timeout), 32'h0);
    check_eq("nowd_en", 32'(b_core_en), 32'h3);
    check_eq("nowd_no_vga", 32'(b_pulses), 32'd1);
`endif

    // A: done during core reset ignored, then reset mid-run wins over an exit
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_core_done = 2'b01;
    tick();
    tick();
    a_core_done = 2'b00;
    tick();
    tick();
    check_eq("crst_done_ignored", 32'(a_core_en), 32'h3);
    repeat (12) tick();
    check_eq("mid_run_count", a_count, 32'd12);
    rst = 1'b1;
    a_core_done = 2'b11;
    tick();
    rst = 1'b0;
    a_core_done = 2'b00;
    check_eq("mrst_core_rst", 32'(a_core_rst), 32'h3);
    check_eq("mrst_core_en", 32'(a_core_en), 32'h0);
    check_eq("mrst_vga_start", 32'(a_vga_start), 32'h0);
    check_eq("mrst_busy", 32'(a_busy), 32'h0);
    check_eq("mrst_finished", 32'(a_finished), 32'h0);
    check_eq("mrst_count", a_count, 32'h0);
    tick();
    check_eq("mrst_stays_idle", 32'(a_busy), 32'h0);
    check_eq("mrst_no_pulse", 32'(a_pulses), 32'd1);
    check_eq("b_after_rst_busy", 32'(b_busy), 32'h0);
    check_eq("b_after_rst_timeout", 32'(b_timeout), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
